// File: rtl/sim_pmem_port_if.sv
// Request/response channel bundle between a CPU memory port (master) and sim_pmem_port (slave).
interface sim_pmem_port_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W/8-1:0] req_mask;
  logic                resp_valid;
  logic                resp_ready;
  logic [DATA_W-1:0]   resp_rdata;
  logic                resp_err;
  logic                resp_write;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_mask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_write
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_mask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_write
  );
endinterface

// File: rtl/sim_pmem_port.sv
// Simulation memory port: valid/ready request+response, LATENCY-deep pipe, DEPTH credits, in-order responses.
// SIM_PMEM_RAND_STALL_EN adds LFSR-driven req_ready stalls.
module sim_pmem_port #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  sim_pmem_port_if.slave bus
);
  localparam int unsigned LANES  = DATA_W / 32;
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned OFS_W  = $clog2(MASK_W);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic              err;
    logic              write;
    logic [DATA_W-1:0] rdata;
  } resp_t;

  // Word-addressed sparse store standing in for host pmem; unwritten words read as zero.
  int unsigned pmem_words [int unsigned];

  function automatic int unsigned verilog_pmem_read(input int unsigned raddr);
    int unsigned key;
    key = raddr & ~32'd3;
    return pmem_words.exists(key) ? pmem_words[key] : 32'd0;
  endfunction

  function automatic void verilog_pmem_write(input int unsigned waddr, input int unsigned wdata,
                                             input byte unsigned wmask);
    int unsigned cur;
    cur = verilog_pmem_read(waddr);
    for (int b = 0; b < 4; b++) begin
      if (wmask[b]) cur[8*b +: 8] = wdata[8*b +: 8];
    end
    pmem_words[waddr & ~32'd3] = cur;
  endfunction

  logic               acc;
  logic               pop;
  logic               misaligned;
  logic               stall_c;
  logic [LATENCY-1:0] pipe_vld;
  resp_t              pipe_ent [LATENCY];
  logic               push;
  resp_t              push_ent;
  resp_t              fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  logic [CNT_W-1:0]   credits;
  logic [CNT_W-1:0]   credits_nxt;
  logic               load;
  logic               take;
  logic               fifo_wr;
  logic               out_vld;
  resp_t              out_ent;
  logic               req_ready_q;

  assign acc        = bus.req_valid & req_ready_q;
  assign pop        = out_vld & bus.resp_ready;
  assign misaligned = |bus.req_addr[OFS_W-1:0];
  assign push       = pipe_vld[LATENCY-1];
  assign push_ent   = pipe_ent[LATENCY-1];

  // Output register refills when empty or popped; queued entries take priority over a fresh push.
  assign load        = !out_vld || pop;
  assign take        = load && (fifo_cnt != '0);
  assign fifo_wr     = push && !(load && (fifo_cnt == '0));
  assign credits_nxt = credits + CNT_W'(acc) - CNT_W'(pop);

`ifdef SIM_PMEM_RAND_STALL_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_nxt;

  assign lfsr_nxt = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign stall_c  = lfsr_nxt[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= 16'hACE1;
    else          lfsr_q <= lfsr_nxt;
  end
`else
  assign stall_c = 1'b0;
`endif

  // Latency pipe; pmem is touched only at the accept edge so side effects follow acceptance order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < int'(LATENCY); i++) pipe_ent[i] <= '0;
    end else begin
      pipe_vld[0] <= acc;
      pipe_ent[0] <= '0;
      for (int i = 1; i < int'(LATENCY); i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_ent[i] <= pipe_ent[i-1];
      end
      if (acc) begin
        pipe_ent[0].err   <= misaligned;
        pipe_ent[0].write <= bus.req_write;
        if (!misaligned) begin
          for (int l = 0; l < int'(LANES); l++) begin
            if (bus.req_write) begin
              if (|bus.req_mask[4*l +: 4])
                verilog_pmem_write(32'(bus.req_addr + ADDR_W'(4*l)), bus.req_wdata[32*l +: 32],
                                   8'(bus.req_mask[4*l +: 4]));
            end else begin
              pipe_ent[0].rdata[32*l +: 32] <= verilog_pmem_read(32'(bus.req_addr + ADDR_W'(4*l)));
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= push_ent;
  end

  // Response head register, queue pointers and credit-based req_ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_vld     <= 1'b0;
      out_ent     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      credits     <= '0;
      req_ready_q <= 1'b0;
    end else begin
      if (load) begin
        if (take) begin
          out_vld <= 1'b1;
          out_ent <= fifo_mem[rd_ptr];
        end else if (push) begin
          out_vld <= 1'b1;
          out_ent <= push_ent;
        end else begin
          out_vld <= 1'b0;
          out_ent <= '0;
        end
      end
      if (take)    rd_ptr <= rd_ptr + PTR_W'(1);
      if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      fifo_cnt    <= fifo_cnt + CNT_W'(fifo_wr) - CNT_W'(take);
      credits     <= credits_nxt;
      req_ready_q <= (credits_nxt < CNT_W'(DEPTH)) && !stall_c;
    end
  end

  queue_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(fifo_wr && (fifo_cnt == CNT_W'(DEPTH))));

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = out_vld;
  assign bus.resp_rdata = out_ent.rdata;
  assign bus.resp_err   = out_ent.err;
  assign bus.resp_write = out_ent.write;
endmodule

// File: tb/tb_sim_pmem_port.sv
// Self-checking bench for sim_pmem_port: vector table, backpressure/full and reset sequences, random vs model.
module tb_sim_pmem_port;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic reset3_n;

  always #5 clk = ~clk;

  sim_pmem_port_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  sim_pmem_port_if #(.ADDR_W(32), .DATA_W(64)) bus3 ();

  sim_pmem_port #(.ADDR_W(32), .DATA_W(32), .LATENCY(1), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
  sim_pmem_port #(.ADDR_W(32), .DATA_W(64), .LATENCY(3), .DEPTH(DEPTH)) u_dut3 (
    .clk(clk), .reset_n(reset3_n), .bus(bus3));

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        wr;
    int          acc_edge;
  } exp_t;

  vec_t        vecs [14];
  exp_t        expq [$];
  bit   [31:0] mem_m [bit [31:0]];
  int          n_checks = 0;
  int          n_errs   = 0;
  int          n_acc, n_pop, lat, edge_no, credits_m, k;
  logic        acc_now, pop_now, pending;
  logic [31:0] a, cur;
  exp_t        e;
  logic [31:0] full_rd   [6];
  logic        full_err  [6];
  logic [31:0] full_addr [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_main();
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_mask = '0; bus.resp_ready = 0;
  endtask

  task automatic idle3();
    bus3.req_valid = 0; bus3.req_write = 0; bus3.req_addr = '0;
    bus3.req_wdata = '0; bus3.req_mask = '0; bus3.resp_ready = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int w;
    w = 0;
    while (!bus.req_ready && w < 20) begin tick(); w++; end
    chk($sformatf("vec%0d_ready", idx), bus.req_ready, 1'b1);
    bus.req_valid = 1; bus.req_write = v.wr; bus.req_addr = v.addr;
    bus.req_wdata = v.wdata; bus.req_mask = v.mask;
    tick();
    bus.req_valid = 0;
    lat = 0;
    while (!bus.resp_valid && lat < 10) begin tick(); lat++; end
    chk($sformatf("vec%0d_latency", idx), lat, 1);
    chk($sformatf("vec%0d_rdata", idx), bus.resp_rdata, v.rdata);
    chk($sformatf("vec%0d_err", idx), bus.resp_err, v.err);
    chk($sformatf("vec%0d_write", idx), bus.resp_write, v.wr);
    bus.resp_ready = 1;
    tick();
    bus.resp_ready = 0;
    chk($sformatf("vec%0d_popped", idx), bus.resp_valid, 1'b0);
  endtask

  task automatic run3(input logic wr, input logic [31:0] ad, input logic [63:0] wd, input logic [7:0] mk,
                      input logic [63:0] exp_rd, input logic exp_err, input string name);
    chk({name, "_ready"}, bus3.req_ready, 1'b1);
    bus3.req_valid = 1; bus3.req_write = wr; bus3.req_addr = ad;
    bus3.req_wdata = wd; bus3.req_mask = mk;
    tick();
    bus3.req_valid = 0;
    lat = 0;
    while (!bus3.resp_valid && lat < 12) begin tick(); lat++; end
    chk({name, "_latency"}, lat, 3);
    chk({name, "_rdata"}, bus3.resp_rdata, exp_rd);
    chk({name, "_err"}, bus3.resp_err, exp_err);
    chk({name, "_write"}, bus3.resp_write, wr);
    bus3.resp_ready = 1;
    tick();
    bus3.resp_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 32'h8000_0004, 32'h1122_3344, 4'h3, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 32'h8000_0004, 32'h0,         4'h0, 32'hFFFF_3344, 1'b0};
    vecs[5]  = '{1'b0, 32'h8000_0002, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[6]  = '{1'b1, 32'h8000_0001, 32'h1234_5678, 4'hF, 32'h0,         1'b1};
    vecs[7]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[8]  = '{1'b1, 32'h8000_0004, 32'hAABB_CCDD, 4'h0, 32'h0,         1'b0};
    vecs[9]  = '{1'b0, 32'h8000_0004, 32'h0,         4'h0, 32'hFFFF_3344, 1'b0};
    vecs[10] = '{1'b1, 32'h8000_0008, 32'hCAFE_F00D, 4'hC, 32'h0,         1'b0};
    vecs[11] = '{1'b0, 32'h8000_0008, 32'h0,         4'h0, 32'hCAFE_0000, 1'b0};
    vecs[12] = '{1'b1, 32'h8000_0008, 32'hA5A5_A5A5, 4'h4, 32'h0,         1'b0};
    vecs[13] = '{1'b0, 32'h8000_0008, 32'h0,         4'h0, 32'hCAA5_0000, 1'b0};

    full_addr = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_0002, 32'h8000_0000, 32'h8000_0004};
    full_rd   = '{32'hDEAD_BEEF, 32'hFFFF_3344, 32'hCAA5_0000, 32'h0,         32'hDEAD_BEEF, 32'hFFFF_3344};
    full_err  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset: all outputs low while asserted, req_ready on the first edge after release.
    reset_n = 0; reset3_n = 0;
    idle_main(); idle3();
    repeat (3) begin
      tick();
      chk("rst_req_ready", bus.req_ready, 1'b0);
      chk("rst_resp_valid", bus.resp_valid, 1'b0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
      chk("rst_resp_err", bus.resp_err, 1'b0);
      chk("rst_resp_write", bus.resp_write, 1'b0);
      chk("rst3_req_ready", bus3.req_ready, 1'b0);
    end
    @(negedge clk);
    reset_n = 1; reset3_n = 1;
    #1;
    chk("release_no_comb_ready", bus.req_ready, 1'b0);
    tick();
    chk("release_req_ready", bus.req_ready, 1'b1);
    chk("release3_req_ready", bus3.req_ready, 1'b1);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Full window: six back-to-back reads with the consumer stalled.
    n_acc = 0;
    bus.resp_ready = 0;
    bus.req_valid = 1; bus.req_write = 0; bus.req_addr = full_addr[0];
    for (int c = 0; c < 12; c++) begin
      acc_now = bus.req_valid && bus.req_ready;
      tick();
      if (acc_now) begin
        n_acc++;
        bus.req_addr = full_addr[n_acc];
        if (n_acc == 4) chk("full_ready_drop", bus.req_ready, 1'b0);
        if (n_acc == 3) chk("full_ready_at3", bus.req_ready, 1'b1);
      end
    end
    chk("full_accepts", n_acc, 4);
    chk("full_ready_held", bus.req_ready, 1'b0);
    chk("full_head_valid", bus.resp_valid, 1'b1);
    chk("full_head_rdata", bus.resp_rdata, full_rd[0]);
    bus.resp_ready = 1;
    chk("full_no_comb_ready", bus.req_ready, 1'b0);
    n_pop = 0;
    for (int c = 0; c < 40 && n_pop < 6; c++) begin
      acc_now = bus.req_valid && bus.req_ready;
      pop_now = bus.resp_valid;
      if (pop_now) begin
        chk($sformatf("full_rdata%0d", n_pop), bus.resp_rdata, full_rd[n_pop]);
        chk($sformatf("full_err%0d", n_pop), bus.resp_err, full_err[n_pop]);
      end
      tick();
      if (acc_now) begin
        n_acc++;
        if (n_acc < 6) bus.req_addr = full_addr[n_acc];
        else bus.req_valid = 0;
      end
      if (pop_now) n_pop++;
    end
    chk("full_total_accepts", n_acc, 6);
    chk("full_total_pops", n_pop, 6);
    idle_main();
    tick();

    // Random traffic against a transaction-level model of memory, ordering, latency and credits.
    edge_no = 0; credits_m = 0; pending = 0;
    for (int c = 0; c < 500; c++) begin
      if (!pending) begin
        if (c < 450 && $urandom_range(0, 3) != 0) begin
          k = int'($urandom_range(0, 7));
          a = 32'h8000_1000 + 32'(4 * k);
          if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
          bus.req_valid = 1;
          bus.req_addr  = a;
          bus.req_write = 1'($urandom_range(0, 1));
          bus.req_wdata = $urandom();
          bus.req_mask  = 4'($urandom_range(0, 15));
        end else begin
          bus.req_valid = 0;
        end
      end
      bus.resp_ready = (c >= 450) ? 1'b1 : 1'($urandom_range(0, 1));
      acc_now = bus.req_valid && bus.req_ready;
      pop_now = bus.resp_valid && bus.resp_ready;
      if (pop_now) begin
        if (expq.size() == 0) begin
          chk("rnd_spurious_resp", 1'b1, 1'b0);
        end else begin
          e = expq.pop_front();
          chk("rnd_rdata", bus.resp_rdata, e.rdata);
          chk("rnd_err", bus.resp_err, e.err);
          chk("rnd_write", bus.resp_write, e.wr);
        end
      end
      if (acc_now) begin
        a = bus.req_addr;
        e = '{32'h0, 1'b0, bus.req_write, edge_no + 1};
        if (a[1:0] != 2'b00) begin
          e.err = 1'b1;
        end else if (bus.req_write) begin
          cur = mem_m.exists(a) ? mem_m[a] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (bus.req_mask[b]) cur[8*b +: 8] = bus.req_wdata[8*b +: 8];
          mem_m[a] = cur;
        end else begin
          e.rdata = mem_m.exists(a) ? mem_m[a] : 32'h0;
        end
        expq.push_back(e);
      end
      pending = bus.req_valid && !acc_now;
      tick();
      edge_no++;
      credits_m = credits_m + int'(acc_now) - int'(pop_now);
      chk("rnd_req_ready", bus.req_ready, credits_m < int'(DEPTH));
      chk("rnd_resp_valid", bus.resp_valid, (expq.size() > 0) && (edge_no - expq[0].acc_edge >= 1));
    end
    chk("rnd_drained", expq.size(), 0);
    idle_main();

    // 64-bit lanes at LATENCY=3, including a lane-misaligned request.
    run3(1'b1, 32'h8000_0100, 64'h0123_4567_89AB_CDEF, 8'hF0, 64'h0, 1'b0, "w64_hi");
    run3(1'b0, 32'h8000_0100, 64'h0, 8'h00, 64'h0123_4567_0000_0000, 1'b0, "r64_hi");
    run3(1'b1, 32'h8000_0100, 64'hFFFF_FFFF_8765_4321, 8'h0F, 64'h0, 1'b0, "w64_lo");
    run3(1'b0, 32'h8000_0100, 64'h0, 8'h00, 64'h0123_4567_8765_4321, 1'b0, "r64_full");
    run3(1'b0, 32'h8000_0104, 64'h0, 8'h00, 64'h0, 1'b1, "r64_misaligned");

    // Reset with two reads in flight: nothing emerges and the credit window is whole again.
    bus3.req_valid = 1; bus3.req_write = 0; bus3.req_addr = 32'h8000_0100;
    tick(); tick();
    bus3.req_valid = 0;
    #2 reset3_n = 0;
    #1;
    chk("midrst_req_ready", bus3.req_ready, 1'b0);
    chk("midrst_resp_valid", bus3.resp_valid, 1'b0);
    chk("midrst_resp_rdata", bus3.resp_rdata, 64'h0);
    tick();
    chk("midrst_resp_valid_hold", bus3.resp_valid, 1'b0);
    @(negedge clk);
    reset3_n = 1;
    tick();
    chk("midrst_release_ready", bus3.req_ready, 1'b1);
    for (int c = 0; c < 8; c++) begin
      chk("midrst_no_resp", bus3.resp_valid, 1'b0);
      tick();
    end
    n_acc = 0;
    bus3.resp_ready = 0;
    bus3.req_valid = 1; bus3.req_write = 0; bus3.req_addr = 32'h8000_0100;
    for (int c = 0; c < 10; c++) begin
      acc_now = bus3.req_valid && bus3.req_ready;
      tick();
      if (acc_now) n_acc++;
    end
    bus3.req_valid = 0;
    chk("midrst_credit_accepts", n_acc, 4);
    chk("midrst_credit_full", bus3.req_ready, 1'b0);
    bus3.resp_ready = 1;
    n_pop = 0;
    for (int c = 0; c < 30 && n_pop < 4; c++) begin
      if (bus3.resp_valid) begin
        chk("midrst_persist_rdata", bus3.resp_rdata, 64'h0123_4567_8765_4321);
        n_pop++;
      end
      tick();
    end
    chk("midrst_pops", n_pop, 4);
    idle3();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
